// File: rtl/rr_onehot_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_onehot_arbiter
// Brief    : Round-robin arbiter with a one-hot-or-zero grant and a hold limit.
// Revision : 1.0 - initial release
// ============================================================================
module rr_onehot_arbiter #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req_i,
    input  logic [N-1:0]         done_i,
    output logic [N-1:0]         grant_o,
    output logic [$clog2(N)-1:0] grant_id_o,
    output logic                 busy_o,
    output logic                 timeout_o
);

    localparam int             IDW         = $clog2(N);
    localparam logic [IDW:0]   c_N         = (IDW+1)'(N);
    localparam logic [IDW-1:0] c_LAST_IDX  = IDW'(N-1);
    localparam logic [7:0]     c_HOLD_LAST = 8'(MAX_HOLD-1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_OWNED = 1'b1
    } state_t;

    state_t         state_q;
    logic [N-1:0]   grant_q;
    logic [IDW-1:0] grant_id_q;
    logic [IDW-1:0] owner_q;
    logic [IDW-1:0] ptr_q;
    logic [7:0]     hold_cnt_q;
    logic           timeout_q;

    logic [IDW-1:0] w_scan_idx [N];
    logic [IDW-1:0] w_sel_idx;
    logic           w_any_req;
    logic [N-1:0]   w_sel_onehot;
    logic           w_own_done;
    logic           w_own_req;
    logic           w_hold_last;
    logic           w_release;
    logic           w_timeout;
    logic [IDW-1:0] w_ptr_next;

    // Scan order starting at the priority pointer, wrapping modulo N.
    for (genvar k = 0; k < N; k++) begin : g_scan
        logic [IDW:0] w_sum;
        assign w_sum         = {1'b0, ptr_q} + (IDW+1)'(k);
        assign w_scan_idx[k] = (w_sum >= c_N) ? IDW'(w_sum - c_N) : IDW'(w_sum);
    end

    // Walk from lowest to highest priority so the highest-priority hit wins.
    always_comb begin
        w_sel_idx = '0;
        w_any_req = 1'b0;
        for (int k = N-1; k >= 0; k--) begin
            if (req_i[w_scan_idx[k]]) begin
                w_sel_idx = w_scan_idx[k];
                w_any_req = 1'b1;
            end
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_onehot
        assign w_sel_onehot[i] = (w_sel_idx == IDW'(i));
    end

    assign w_own_done  = done_i[owner_q];
    assign w_own_req   = req_i[owner_q];
    assign w_hold_last = (hold_cnt_q == c_HOLD_LAST);
    assign w_release   = w_own_done | ~w_own_req | w_hold_last;
    // A timeout is flagged only when the limit is the sole release cause.
    assign w_timeout   = w_hold_last & w_own_req & ~w_own_done;
    assign w_ptr_next  = (owner_q == c_LAST_IDX) ? '0 : owner_q + IDW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            grant_q    <= '0;
            grant_id_q <= '0;
            owner_q    <= '0;
            ptr_q      <= '0;
            hold_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (w_any_req) begin
                        state_q    <= S_OWNED;
                        grant_q    <= w_sel_onehot;
                        grant_id_q <= w_sel_idx;
                        owner_q    <= w_sel_idx;
                        hold_cnt_q <= '0;
                    end
                end
                S_OWNED: begin
                    if (w_release) begin
                        state_q    <= S_IDLE;
                        grant_q    <= '0;
                        grant_id_q <= '0;
                        ptr_q      <= w_ptr_next;
                        hold_cnt_q <= '0;
                        timeout_q  <= w_timeout;
                    end else begin
                        hold_cnt_q <= hold_cnt_q + 8'd1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    grant_q <= '0;
                end
            endcase
        end
    end

    assign grant_o    = grant_q;
    assign grant_id_o = grant_id_q;
    assign busy_o     = |grant_q;
    assign timeout_o  = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_rr_onehot_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_rr_onehot_arbiter
// Brief    : Scoreboard bench for rr_onehot_arbiter (N=4, MAX_HOLD=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_rr_onehot_arbiter;

    localparam int N        = 4;
    localparam int MAX_HOLD = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] req_i = '0;
    logic [N-1:0] done_i = '0;
    logic [N-1:0] grant_o;
    logic [1:0]   grant_id_o;
    logic         busy_o;
    logic         timeout_o;

    rr_onehot_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_i      (req_i),
        .done_i     (done_i),
        .grant_o    (grant_o),
        .grant_id_o (grant_id_o),
        .busy_o     (busy_o),
        .timeout_o  (timeout_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] g;
        logic [1:0]   id;
        logic         t;
        string        name;
    } exp_t;

    exp_t exp_q[$];
    int   tests   = 0;
    int   fails   = 0;
    bit   started = 1'b0;

    // One cycle of stimulus; expected outputs after the coming edge are queued.
    task automatic step(input logic r, input logic [N-1:0] rq, input logic [N-1:0] dn,
                        input logic [N-1:0] eg, input logic et, input string nm);
        exp_t e;
        @(negedge clk);
        rst    = r;
        req_i  = rq;
        done_i = dn;
        e.g    = eg;
        e.t    = et;
        e.name = nm;
        e.id   = '0;
        for (int i = 0; i < N; i++) if (eg[i]) e.id = 2'(i);
        exp_q.push_back(e);
        started = 1'b1;
    endtask

    // Monitor: invariants every cycle, scoreboard compare when an entry is due.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (started) begin
                tests++;
                if ($countones(grant_o) > 1) begin
                    fails++;
                    $display("FAIL onehot: grant=%b, required at most one bit set", grant_o);
                end
                tests++;
                if (busy_o !== |grant_o) begin
                    fails++;
                    $display("FAIL busy: busy=%b, required %b", busy_o, |grant_o);
                end
                tests++;
                if ((grant_o & ~req_i) != '0) begin
                    fails++;
                    $display("FAIL grant_req: grant=%b, req at edge=%b", grant_o, req_i);
                end
                tests++;
                if (timeout_o && busy_o) begin
                    fails++;
                    $display("FAIL timeout_idle: timeout=1 busy=1, required busy=0");
                end
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                tests++;
                if (grant_o !== e.g || busy_o !== |e.g || timeout_o !== e.t ||
                    (|e.g && grant_id_o !== e.id)) begin
                    fails++;
                    $display("FAIL %s: grant=%b id=%0d busy=%b timeout=%b, required grant=%b id=%0d busy=%b timeout=%b",
                             e.name, grant_o, grant_id_o, busy_o, timeout_o,
                             e.g, e.id, |e.g, e.t);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        step(1, 4'b0000, 4'b0000, 4'b0000, 0, "reset0");
        step(1, 4'b0000, 4'b1111, 4'b0000, 0, "reset1");
        step(0, 4'b0000, 4'b1111, 4'b0000, 0, "idle_done_ignored");

        // Single requester, done in third grant cycle
        step(0, 4'b0001, 4'b0000, 4'b0001, 0, "single_g1");
        step(0, 4'b0001, 4'b0000, 4'b0001, 0, "single_g2");
        step(0, 4'b0001, 4'b0000, 4'b0001, 0, "single_g3");
        step(0, 4'b0001, 4'b0001, 4'b0000, 0, "single_release");
        step(0, 4'b0011, 4'b0000, 4'b0010, 0, "single_ptr_is_1");
        step(0, 4'b0000, 4'b0000, 4'b0000, 0, "req_drop_release");

        // Rotation and wrap from a fresh pointer
        step(1, 4'b0000, 4'b0000, 4'b0000, 0, "rot_reset");
        step(0, 4'b1111, 4'b0000, 4'b0001, 0, "rot_g0");
        step(0, 4'b1111, 4'b0001, 4'b0000, 0, "rot_gap0");
        step(0, 4'b1111, 4'b0000, 4'b0010, 0, "rot_g1");
        step(0, 4'b1111, 4'b0010, 4'b0000, 0, "rot_gap1");
        step(0, 4'b1111, 4'b0000, 4'b0100, 0, "rot_g2");
        step(0, 4'b1111, 4'b0100, 4'b0000, 0, "rot_gap2");
        step(0, 4'b1111, 4'b0000, 4'b1000, 0, "rot_g3");
        step(0, 4'b1111, 4'b1000, 4'b0000, 0, "rot_gap3");
        step(0, 4'b1111, 4'b0000, 4'b0001, 0, "rot_wrap_g0");
        step(0, 4'b1111, 4'b0001, 4'b0000, 0, "rot_wrap_gap");

        // Timeout: pointer is 1, only requester 2 asks
        for (int i = 0; i < MAX_HOLD; i++)
            step(0, 4'b0100, 4'b0000, 4'b0100, 0, "to_hold");
        step(0, 4'b0100, 4'b0000, 4'b0000, 1, "to_release");
        step(0, 4'b0100, 4'b0000, 4'b0100, 0, "to_regrant_wrap");

        // Coincident limit and done in the eighth grant cycle
        for (int i = 1; i < MAX_HOLD; i++)
            step(0, 4'b0100, 4'b0000, 4'b0100, 0, "coin_hold");
        step(0, 4'b0100, 4'b0100, 4'b0000, 0, "coin_release_no_to");

        // Non-owner done, then reset mid-grant (pointer is 3)
        step(0, 4'b0010, 4'b0000, 4'b0010, 0, "nod_grant1");
        step(0, 4'b0010, 4'b0100, 4'b0010, 0, "nod_ignored");
        step(0, 4'b0110, 4'b0000, 4'b0010, 0, "nonowner_req_ignored");
        step(1, 4'b0010, 4'b0000, 4'b0000, 0, "midgrant_reset");
        step(0, 4'b0010, 4'b0000, 4'b0010, 0, "after_reset_regrant");
        step(0, 4'b0000, 4'b0000, 4'b0000, 0, "final_release");

        // Random traffic checked by the monitor invariants
        for (int c = 0; c < 10000; c++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, 3) == 0) req_i = 4'($urandom);
            done_i = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'b0000;
        end

        @(negedge clk);
        @(negedge clk);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
